// File: rtl/pls_pkg.sv
// Shared state encoding and period clamp for the multi-axis step/dir controller.
package pls_pkg;

    typedef enum logic [2:0] {IDLE, OI, DIRSET, RUN, ERR} state_t;

    // A period must hold the PW-cycle high phase plus an equally long low phase.
    function automatic logic [31:0] t_eff(input logic [31:0] t, input int unsigned pw);
        logic [31:0] lim;
        lim = 32'(2 * pw);
        return (t < lim) ? lim : t;
    endfunction

endpackage

// File: rtl/pls_axis.sv
// One step channel: pulse counter, period timer, pulse-width stretcher and finished flag.
module pls_axis #(
    parameter int CW = 32,
    parameter int TW = 32,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic          en,
    input  logic          green,
    input  logic [CW-1:0] n,
    input  logic [TW-1:0] t_eff,
    output logic          pls,
    output logic          pls_clk,
    output logic          fin
);

    localparam int HW = $clog2(PW + 1);

    logic [CW-1:0] cnt;
    logic [TW-1:0] tmr, per;
    logic [HW-1:0] hcnt;
    logic          fire;

    assign fire    = en && green && (tmr == '0) && (cnt != '0);
    assign pls_clk = fire;
    assign pls     = fire || (hcnt != '0);
    // Finished only once the period after the last pulse has fully elapsed.
    assign fin     = (cnt == '0) && (tmr == '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt  <= '0;
            tmr  <= '0;
            per  <= '0;
            hcnt <= '0;
        end else if (load) begin
            cnt  <= n;
            per  <= t_eff;
            tmr  <= '0;
            hcnt <= '0;
        end else if (en && green) begin
            if (fire) begin
                cnt  <= cnt - CW'(1);
                hcnt <= HW'(PW - 1);
                tmr  <= TW'(1);
            end else begin
                if (hcnt != '0)
                    hcnt <= hcnt - HW'(1);
                if (tmr != '0)
                    tmr <= (tmr == per - TW'(1)) ? '0 : tmr + TW'(1);
            end
        end
    end

endmodule

// File: rtl/pls_cont_multi.sv
// Multi-axis step/dir controller: segment FSM, one-deep prefetch shadow, FIFO handshake
// and direction setup timer around an array of pls_axis channels.
module pls_cont_multi
    import pls_pkg::*;
#(
    parameter int AXES      = 2,
    parameter int CW        = 32,
    parameter int TW        = 32,
    parameter int PW        = 8,
    parameter int DIR_SETUP = 16
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 abort,
    input  logic                 brake,
    input  logic                 green,
    input  logic                 oi,
    input  logic                 empty,
    input  logic [AXES*CW-1:0]   N,
    input  logic [AXES*TW-1:0]   T,
    input  logic [AXES-1:0]      dir_in,
    output logic                 rdack,
    output logic                 ready,
    output logic                 oi_req,
    output logic                 run,
    output logic                 seg_done,
    output logic                 err,
    output logic [AXES-1:0]      pls,
    output logic [AXES-1:0]      dir,
    output logic [AXES-1:0]      pls_clk
);

    localparam int DW = $clog2(DIR_SETUP + 1);

    state_t                  state, state_nx;
    logic [AXES-1:0][CW-1:0] in_n, act_n, shd_n, ax_n;
    logic [AXES-1:0][TW-1:0] in_t, act_t, shd_t, ax_t;
    logic [AXES-1:0]         act_dir, shd_dir, fin;
    logic                    shd_vld, rdack_q, stop, can_rd, all_fin, in_zero, run_en;
    logic                    rd_idle, rd_pf, ld_act, ld_shd;
    logic [DW-1:0]           dcnt;

    for (genvar i = 0; i < AXES; i++) begin : g_in
        assign in_n[i] = N[i*CW +: CW];
        assign in_t[i] = TW'(t_eff(32'(T[i*TW +: TW]), PW));
    end

    assign stop    = aclr | abort | brake;
    assign in_zero = (N == '0);
    assign all_fin = &fin;
    // Spacing reads gives the FIFO a cycle to update empty after each acknowledge.
    assign can_rd  = !empty && !rdack_q;
    assign run_en  = (state == RUN);

    always_comb begin
        state_nx = state;
        rd_idle  = 1'b0;
        rd_pf    = 1'b0;
        ld_act   = 1'b0;
        ld_shd   = 1'b0;
        case (state)
            IDLE: if (can_rd) begin
                rd_idle = 1'b1;
                if (!in_zero) state_nx = OI;
            end
            OI: if (oi) begin
                if (act_dir != dir) state_nx = DIRSET;
                else begin
                    state_nx = RUN;
                    ld_act   = 1'b1;
                end
            end
            DIRSET: begin
                rd_pf = !shd_vld && can_rd;
                if (dcnt == '0) begin
                    state_nx = RUN;
                    ld_act   = 1'b1;
                end
            end
            RUN: if (all_fin) begin
                if (!shd_vld)             state_nx = IDLE;
                else if (shd_dir != dir)  state_nx = DIRSET;
                else                      ld_shd   = 1'b1;
            end else begin
                rd_pf = !shd_vld && can_rd;
            end
            default: ;
        endcase
    end

    assign rdack    = (rd_idle | rd_pf) & ~stop;
    assign seg_done = ((run_en & all_fin) | (rd_idle & in_zero)) & ~stop;
    assign ready    = (state == IDLE);
    assign oi_req   = (state == OI);
    assign run      = (state == DIRSET) || (state == RUN);
    assign err      = (state == ERR);
    assign ax_n     = ld_shd ? shd_n : act_n;
    assign ax_t     = ld_shd ? shd_t : act_t;

    always_ff @(posedge clk) begin
        if (aclr || abort || (brake && state != ERR)) begin
            state   <= (!aclr && abort) ? ERR : IDLE;
            dir     <= '0;
            shd_vld <= 1'b0;
            rdack_q <= 1'b0;
            dcnt    <= '0;
        end else begin
            state   <= state_nx;
            rdack_q <= rdack;
            if (rd_idle) begin
                act_n   <= in_n;
                act_t   <= in_t;
                act_dir <= dir_in;
            end
            if (rd_pf) begin
                shd_n   <= in_n;
                shd_t   <= in_t;
                shd_dir <= dir_in;
                shd_vld <= 1'b1;
            end
            if (run_en && all_fin && shd_vld) begin
                act_n   <= shd_n;
                act_t   <= shd_t;
                act_dir <= shd_dir;
                shd_vld <= 1'b0;
            end
            // dir moves on DIRSET entry, then DIR_SETUP cycles elapse before RUN.
            if (state_nx == DIRSET && state != DIRSET) begin
                dir  <= (state == RUN) ? shd_dir : act_dir;
                dcnt <= DW'(DIR_SETUP - 1);
            end else if (dcnt != '0) begin
                dcnt <= dcnt - DW'(1);
            end
        end
    end

    for (genvar i = 0; i < AXES; i++) begin : g_ax
        pls_axis #(.CW(CW), .TW(TW), .PW(PW)) u_ax (
            .clk     (clk),
            .clr     (stop),
            .load    (ld_act | ld_shd),
            .en      (run_en),
            .green   (green),
            .n       (ax_n[i]),
            .t_eff   (ax_t[i]),
            .pls     (pls[i]),
            .pls_clk (pls_clk[i]),
            .fin     (fin[i])
        );
    end

endmodule

// File: tb/tb_pls_cont_multi.sv
// Directed bench for pls_cont_multi: FWFT FIFO model, per-cycle event recorder, assertion checks.
module tb_pls_cont_multi;

    localparam int AXES = 2;
    localparam int CW   = 32;
    localparam int TW   = 32;

    logic                clk, aclr, abort, brake, green, oi, empty;
    logic [AXES*CW-1:0]  N;
    logic [AXES*TW-1:0]  T;
    logic [AXES-1:0]     dir_in;
    logic                rdack, ready, oi_req, run, seg_done, err;
    logic [AXES-1:0]     pls, dir, pls_clk;

    pls_cont_multi #(.AXES(AXES), .CW(CW), .TW(TW), .PW(8), .DIR_SETUP(16)) dut (
        .clk(clk), .aclr(aclr), .abort(abort), .brake(brake), .green(green), .oi(oi),
        .empty(empty), .N(N), .T(T), .dir_in(dir_in), .rdack(rdack), .ready(ready),
        .oi_req(oi_req), .run(run), .seg_done(seg_done), .err(err), .pls(pls),
        .dir(dir), .pls_clk(pls_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] n0, n1, t0, t1;
        logic [1:0]  d;
    } seg_t;

    seg_t fq[$];
    int   sd_q[$], pc_q[$];
    int   n_tests, n_fail, cyc, n_rdack, rd_first, n_oireq, pc_first, dchg;
    int   pc_n[AXES], last_pc[AXES], per_ax[AXES], hi_run[AXES], hi_min[AXES], hi_max[AXES];
    bit   pop_p;
    logic [AXES-1:0] s_pls, s_dir;
    logic s_ready, s_err, s_run, s_rdack, s_sd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive();
        if (fq.size() == 0) begin
            empty = 1'b1; N = '0; T = '0; dir_in = '0;
        end else begin
            empty = 1'b0;
            N = {fq[0].n1, fq[0].n0};
            T = {fq[0].t1, fq[0].t0};
            dir_in = fq[0].d;
        end
    endtask

    task automatic push(input int n0, input int n1, input int t0, input int t1, input logic [1:0] d);
        seg_t s;
        s.n0 = n0; s.n1 = n1; s.t0 = t0; s.t1 = t1; s.d = d;
        fq.push_back(s);
        drive();
    endtask

    task automatic reset_stats();
        n_rdack = 0; rd_first = -1; n_oireq = 0; pc_first = -1;
        sd_q.delete(); pc_q.delete();
        for (int a = 0; a < AXES; a++) begin
            pc_n[a] = 0; last_pc[a] = -1; per_ax[a] = -1;
            hi_run[a] = 0; hi_min[a] = 1000; hi_max[a] = 0;
        end
    endtask

    // Sample one cycle at negedge, then pop the FIFO just after the edge that consumed it.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rdack === 1'b1) begin
            n_rdack++; pop_p = 1'b1;
            if (rd_first < 0) rd_first = cyc;
        end
        if (seg_done === 1'b1) sd_q.push_back(cyc);
        if (oi_req === 1'b1) n_oireq++;
        for (int a = 0; a < AXES; a++) begin
            if (pls_clk[a] === 1'b1) begin
                pc_n[a]++;
                if (last_pc[a] >= 0) per_ax[a] = cyc - last_pc[a];
                last_pc[a] = cyc;
                if (pc_first < 0) pc_first = cyc;
                if (pc_q.size() == 0 || pc_q[$] != cyc) pc_q.push_back(cyc);
            end
            if (pls[a] === 1'b1) hi_run[a]++;
            else if (hi_run[a] > 0) begin
                if (hi_run[a] < hi_min[a]) hi_min[a] = hi_run[a];
                if (hi_run[a] > hi_max[a]) hi_max[a] = hi_run[a];
                hi_run[a] = 0;
            end
        end
        if (dir !== s_dir) dchg = cyc;
        s_dir = dir; s_pls = pls; s_ready = ready; s_err = err; s_run = run;
        s_rdack = rdack; s_sd = seg_done;
        @(posedge clk);
        #1;
        if (pop_p) begin
            if (fq.size() > 0) void'(fq.pop_front());
            drive();
            pop_p = 1'b0;
        end
    endtask

    task automatic wait_sd(input int k, input int budget, input string tag);
        int i = 0;
        while (sd_q.size() < k && i < budget) begin
            tick();
            i++;
        end
        chk({tag, "_seg_done_seen"}, 64'(sd_q.size() >= k), 1);
    endtask

    task automatic wait_pulse(input int budget, input string tag);
        int i = 0;
        while (pc_first < 0 && i < budget) begin
            tick();
            i++;
        end
        chk({tag, "_first_pulse_seen"}, 64'(pc_first >= 0), 1);
    endtask

    function automatic int first_after(input int c);
        for (int i = 0; i < pc_q.size(); i++)
            if (pc_q[i] > c) return pc_q[i];
        return -1;
    endfunction

    initial begin
        aclr = 1'b1; abort = 1'b0; brake = 1'b0; green = 1'b1; oi = 1'b1;
        fq.delete(); drive();
        s_dir = '0; dchg = -1; cyc = 0; pop_p = 1'b0; n_tests = 0; n_fail = 0;
        reset_stats();
        repeat (3) tick();
        aclr = 1'b0;
        tick();
        chk("rst_ready", s_ready, 1);
        chk("rst_err", s_err, 0);
        chk("rst_run", s_run, 0);
        chk("rst_pls", s_pls, 0);
        chk("rst_dir", s_dir, 0);
        chk("rst_rdack", s_rdack, 0);
        chk("rst_seg_done", s_sd, 0);

        // All-zero segment: consumed from IDLE, strobes seg_done, no oi handshake.
        reset_stats();
        push(0, 0, 20, 20, 2'b00);
        repeat (4) tick();
        chk("zero_seg_done", sd_q.size(), 1);
        chk("zero_no_oireq", n_oireq, 0);
        chk("zero_rdack", n_rdack, 1);
        chk("zero_no_pulse", pc_q.size(), 0);
        chk("zero_ready", s_ready, 1);

        // One segment; axis 1 (T=10) clamps to 16, so it sets the length at 5*16.
        reset_stats();
        push(3, 5, 20, 10, 2'b00);
        wait_sd(1, 300, "t1");
        chk("t1_start_latency", pc_first - rd_first, 2);
        chk("t1_seg_len", sd_q[0] - pc_first, 80);
        chk("t1_pulses_ax0", pc_n[0], 3);
        chk("t1_pulses_ax1", pc_n[1], 5);
        chk("t1_hi_min_ax0", hi_min[0], 8);
        chk("t1_hi_max_ax0", hi_max[0], 8);
        chk("t1_hi_min_ax1", hi_min[1], 8);
        chk("t1_hi_max_ax1", hi_max[1], 8);
        chk("t1_period_ax0", per_ax[0], 20);
        chk("t1_period_ax1", per_ax[1], 16);
        tick();
        chk("t1_ready_after", s_ready, 1);
        chk("t1_rdack_count", n_rdack, 1);

        // Back-to-back segments through the shadow register.
        reset_stats();
        push(2, 1, 16, 16, 2'b00);
        push(1, 1, 20, 16, 2'b00);
        wait_sd(2, 300, "t2");
        chk("t2_seg1_len", sd_q[0] - pc_first, 32);
        chk("t2_no_gap", first_after(sd_q[0]) - sd_q[0], 1);
        chk("t2_seg2_len", sd_q[1] - sd_q[0], 21);
        chk("t2_rdack_count", n_rdack, 2);

        // Second segment flips axis 0 direction.
        reset_stats();
        push(1, 1, 16, 16, 2'b00);
        push(1, 0, 16, 16, 2'b01);
        wait_sd(2, 300, "t3");
        chk("t3_dir_change_at", dchg - sd_q[0], 1);
        chk("t3_first_pulse_at", first_after(sd_q[0]) - sd_q[0], 17);
        chk("t3_seg2_done_at", sd_q[1] - sd_q[0], 33);
        chk("t3_dir_value", s_dir, 2'b01);

        // T=3 clamps to 2*PW=16; idle axis with N=0.
        reset_stats();
        push(2, 0, 3, 3, 2'b01);
        wait_sd(1, 200, "t4");
        chk("t4_period", per_ax[0], 16);
        chk("t4_seg_len", sd_q[0] - pc_first, 32);
        chk("t4_pulses_ax0", pc_n[0], 2);
        chk("t4_pulses_ax1", pc_n[1], 0);

        // green low for 25 cycles one cycle into a pulse.
        reset_stats();
        push(2, 0, 20, 20, 2'b01);
        wait_pulse(20, "t5");
        tick();
        green = 1'b0;
        repeat (25) tick();
        chk("t5_pls_held", s_pls[0], 1);
        green = 1'b1;
        wait_sd(1, 200, "t5");
        chk("t5_seg_len", sd_q[0] - pc_first, 65);
        chk("t5_pulses", pc_n[0], 2);

        // abort mid-pulse, then FIFO ignored until aclr.
        reset_stats();
        push(4, 0, 20, 20, 2'b01);
        push(4, 0, 20, 20, 2'b01);
        wait_pulse(20, "t6");
        tick();
        chk("t6_prefetched", n_rdack, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("t6_pls_low", s_pls[0], 0);
        chk("t6_err", s_err, 1);
        chk("t6_run", s_run, 0);
        push(1, 0, 16, 16, 2'b01);
        repeat (10) tick();
        chk("t6_no_rdack", n_rdack, 2);
        chk("t6_err_sticky", s_err, 1);
        chk("t6_pulses", pc_n[0], 1);
        fq.delete();
        drive();
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        tick();
        chk("t6_err_cleared", s_err, 0);
        chk("t6_ready", s_ready, 1);
        chk("t6_dir", s_dir, 0);

        // brake mid-pulse discards the prefetched shadow.
        reset_stats();
        push(4, 0, 20, 20, 2'b00);
        push(4, 0, 20, 20, 2'b00);
        wait_pulse(20, "t7");
        tick();
        chk("t7_prefetched", n_rdack, 2);
        brake = 1'b1;
        tick();
        brake = 1'b0;
        tick();
        chk("t7_pls_low", s_pls[0], 0);
        chk("t7_ready", s_ready, 1);
        chk("t7_run", s_run, 0);
        repeat (20) tick();
        chk("t7_no_rdack", n_rdack, 2);
        chk("t7_pulses", pc_n[0], 1);
        push(1, 0, 16, 16, 2'b00);
        wait_sd(1, 100, "t7");
        repeat (40) tick();
        chk("t7_after_pulses", pc_n[0], 2);
        chk("t7_after_segs", sd_q.size(), 1);
        chk("t7_after_rdack", n_rdack, 3);
        chk("t7_after_ready", s_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
